// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: FSM states, opcodes,
// ALU operation codes and branch-type codes, plus small decode helpers.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    RTEXEC = 4'd7,
    ITEXEC = 4'd8,
    ALUWB  = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11,
    ERROR  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_RTYPE = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SLTIU = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_LUI   = 3'b100;
  localparam logic [2:0] ALU_ORI   = 3'b101;

  localparam logic [1:0] BR_BEQ  = 2'b00;
  localparam logic [1:0] BR_BLEZ = 2'b01;
  localparam logic [1:0] BR_BGTZ = 2'b10;
  localparam logic [1:0] BR_BNE  = 2'b11;

  // ALU operation used by an immediate-format instruction
  function automatic logic [2:0] itype_alu_op(input logic [5:0] op);
    case (op)
      OP_SLTIU: return ALU_SLTIU;
      OP_LUI:   return ALU_LUI;
      OP_ORI:   return ALU_ORI;
      default:  return ALU_ADD;
    endcase
  endfunction

  // Branch condition selector for a branch opcode
  function automatic logic [1:0] branch_code(input logic [5:0] op);
    case (op)
      OP_BLEZ: return BR_BLEZ;
      OP_BGTZ: return BR_BGTZ;
      OP_BNE:  return BR_BNE;
      default: return BR_BEQ;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory wait state and flags the
// cycle on which the wait limit is hit. TIMEOUT of 0 never expires.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic active,
  input  logic mem_ready,
  output logic expired
);

  localparam int W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [W-1:0] LAST_V = W'(LAST);

  logic [W-1:0] cnt;

  // Wait-cycle counter: restarted on entry to a wait state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (active && !mem_ready) begin
      cnt <= cnt + W'(1);
    end
  end

  // Expiry fires on the TIMEOUT-th not-ready cycle, so ready that cycle still wins
  always_comb begin
    expired = 1'b0;
    if (TIMEOUT > 0 && active && !mem_ready && cnt == LAST_V) begin
      expired = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: Moore FSM producing datapath controls,
// with memory-wait timeout and a retired-instruction counter.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 3,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [5:0]          instr_op_i,
  input  logic                mem_ready_i,
  output logic                pc_write_o,
  output logic                pc_write_cond_o,
  output logic [1:0]          pc_source_o,
  output logic [1:0]          branch_type_o,
  output logic                ir_write_o,
  output logic                i_or_d_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic [1:0]          mem_to_reg_o,
  output logic                reg_write_o,
  output logic [1:0]          reg_dst_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                extend_mux_o,
  output logic                illegal_o,
  output logic                error_o,
  output logic [CNT_W-1:0]    retire_cnt_o,
  output logic [3:0]          state_o
);

  state_t     state;
  state_t     next_state;
  logic [5:0] op_q;
  logic [2:0] alu_op;
  logic       wait_active;
  logic       wait_clear;
  logic       timed_out;
  logic       retiring;

  assign state_o  = state;
  assign alu_op_o = ALU_OP_W'(alu_op);

  assign wait_active = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign wait_clear  = ((next_state == FETCH) || (next_state == MEMRD) ||
                        (next_state == MEMWR)) && (next_state != state);
  assign retiring    = (next_state == FETCH) &&
                       ((state == MEMWB) || (state == MEMWR) || (state == ALUWB) ||
                        (state == BRANCH) || (state == JUMP));

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .clear     (wait_clear),
    .active    (wait_active),
    .mem_ready (mem_ready_i),
    .expired   (timed_out)
  );

  // State, latched opcode and retire counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      op_q         <= '0;
      retire_cnt_o <= '0;
    end else begin
      state <= next_state;
      if (state == DECODE) begin
        op_q <= instr_op_i;
      end
      if (retiring) begin
        retire_cnt_o <= retire_cnt_o + CNT_W'(1);
      end
    end
  end

  // Next-state selection and Moore control outputs
  always_comb begin
    next_state      = state;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_source_o     = 2'b00;
    branch_type_o   = 2'b00;
    ir_write_o      = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    mem_to_reg_o    = 2'b00;
    reg_write_o     = 1'b0;
    reg_dst_o       = 2'b00;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    alu_op          = ALU_RTYPE;
    extend_mux_o    = 1'b0;
    illegal_o       = 1'b0;
    error_o         = 1'b0;

    case (state)
      IDLE: begin
        next_state = FETCH;
      end
      FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        alu_op      = ALU_ADD;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
        if (mem_ready_i) begin
          next_state = DECODE;
        end else if (timed_out) begin
          next_state = ERROR;
        end
      end
      DECODE: begin
        alu_src_b_o = 2'b11;
        alu_op      = ALU_ADD;
        case (instr_op_i)
          OP_LW, OP_SW:                        next_state = MEMADR;
          OP_RTYPE:                            next_state = RTEXEC;
          OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI:   next_state = ITEXEC;
          OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:    next_state = BRANCH;
          OP_J, OP_JAL:                        next_state = JUMP;
          default: begin
            next_state = FETCH;
            illegal_o  = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op      = ALU_ADD;
        next_state  = (op_q == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
        if (mem_ready_i) begin
          next_state = MEMWB;
        end else if (timed_out) begin
          next_state = ERROR;
        end
      end
      MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 2'b01;
        next_state   = FETCH;
      end
      MEMWR: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
        if (mem_ready_i) begin
          next_state = FETCH;
        end else if (timed_out) begin
          next_state = ERROR;
        end
      end
      RTEXEC: begin
        alu_src_a_o = 1'b1;
        alu_op      = ALU_RTYPE;
        next_state  = ALUWB;
      end
      ITEXEC: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = 2'b10;
        alu_op       = itype_alu_op(op_q);
        extend_mux_o = (op_q == OP_ORI);
        next_state   = ALUWB;
      end
      ALUWB: begin
        // ALU controls are re-derived from op_q so the result stays stable during write-back
        alu_src_a_o = 1'b1;
        reg_write_o = 1'b1;
        if (op_q == OP_RTYPE) begin
          reg_dst_o = 2'b01;
        end else begin
          alu_src_b_o  = 2'b10;
          alu_op       = itype_alu_op(op_q);
          extend_mux_o = (op_q == OP_ORI);
        end
        next_state = FETCH;
      end
      BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op          = ALU_SUB;
        pc_write_cond_o = 1'b1;
        pc_source_o     = 2'b01;
        branch_type_o   = branch_code(op_q);
        next_state      = FETCH;
      end
      JUMP: begin
        pc_write_o  = 1'b1;
        pc_source_o = 2'b10;
        if (op_q == OP_JAL) begin
          reg_write_o  = 1'b1;
          reg_dst_o    = 2'b10;
          mem_to_reg_o = 2'b11;
        end
        next_state = FETCH;
      end
      ERROR: begin
        error_o = 1'b1;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: instruction transactions expand into
// expected per-cycle state/control records; a negedge monitor compares them.
module tb_multicycle_ctrl;
  import cpu_ctrl_pkg::*;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [5:0] instr_op_i;
  logic       mem_ready_i;
  logic       pc_write_o, pc_write_cond_o, ir_write_o, i_or_d_o;
  logic       mem_read_o, mem_write_o, reg_write_o, alu_src_a_o;
  logic       extend_mux_o, illegal_o, error_o;
  logic [1:0] pc_source_o, branch_type_o, mem_to_reg_o, reg_dst_o, alu_src_b_o;
  logic [3:0] alu_op_o;
  logic [1:0] retire_cnt_o;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .ALU_OP_W (4),
    .TIMEOUT  (TO),
    .CNT_W    (2)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .instr_op_i      (instr_op_i),
    .mem_ready_i     (mem_ready_i),
    .pc_write_o      (pc_write_o),
    .pc_write_cond_o (pc_write_cond_o),
    .pc_source_o     (pc_source_o),
    .branch_type_o   (branch_type_o),
    .ir_write_o      (ir_write_o),
    .i_or_d_o        (i_or_d_o),
    .mem_read_o      (mem_read_o),
    .mem_write_o     (mem_write_o),
    .mem_to_reg_o    (mem_to_reg_o),
    .reg_write_o     (reg_write_o),
    .reg_dst_o       (reg_dst_o),
    .alu_src_a_o     (alu_src_a_o),
    .alu_src_b_o     (alu_src_b_o),
    .alu_op_o        (alu_op_o),
    .extend_mux_o    (extend_mux_o),
    .illegal_o       (illegal_o),
    .error_o         (error_o),
    .retire_cnt_o    (retire_cnt_o),
    .state_o         (state_o)
  );

  logic [24:0] act_ctrl;
  assign act_ctrl = {pc_write_o, pc_write_cond_o, pc_source_o, branch_type_o,
                     ir_write_o, i_or_d_o, mem_read_o, mem_write_o, mem_to_reg_o,
                     reg_write_o, reg_dst_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                     extend_mux_o, illegal_o, error_o};

  typedef struct {
    logic [3:0]  st;
    logic [24:0] ctrl;
    logic [1:0]  ret;
  } exp_t;

  exp_t scb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle_no = 0;
  int   model_retire = 0;
  logic [5:0] ops [16];
  bit   to;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cycle_no, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'o00, 6'o02, 6'o03, 6'o04, 6'o05, 6'o06, 6'o07,
                      6'o10, 6'o13, 6'o15, 6'o17, 6'o43, 6'o53};
  endfunction

  function automatic logic [3:0] imm_alu(input logic [5:0] op);
    case (op)
      6'b001011: return 4'd2;
      6'b001111: return 4'd4;
      6'b001101: return 4'd5;
      default:   return 4'd1;
    endcase
  endfunction

  // Expected control word for a state, from the controller's output table
  function automatic logic [24:0] ctrl_for(input logic [3:0] st, input logic [5:0] op,
                                           input logic [5:0] op_in, input logic rdy);
    logic pcw, pcwc, ir, iod, mr, mw, rw, sa, ext, ill, err;
    logic [1:0] pcs, bt, m2r, rd, srcb;
    logic [3:0] alu;
    {pcw, pcwc, ir, iod, mr, mw, rw, sa, ext, ill, err} = '0;
    {pcs, bt, m2r, rd, srcb} = '0;
    alu = '0;
    case (st)
      FETCH:  begin mr = 1; srcb = 2'b01; alu = 4'd1; ir = rdy; pcw = rdy; end
      DECODE: begin srcb = 2'b11; alu = 4'd1; ill = !is_legal(op_in); end
      MEMADR: begin sa = 1; srcb = 2'b10; alu = 4'd1; end
      MEMRD:  begin mr = 1; iod = 1; end
      MEMWB:  begin rw = 1; m2r = 2'b01; end
      MEMWR:  begin mw = 1; iod = 1; end
      RTEXEC: begin sa = 1; end
      ITEXEC: begin sa = 1; srcb = 2'b10; alu = imm_alu(op); ext = (op == 6'b001101); end
      ALUWB: begin
        rw = 1; sa = 1;
        if (op == 6'b000000) rd = 2'b01;
        else begin srcb = 2'b10; alu = imm_alu(op); ext = (op == 6'b001101); end
      end
      BRANCH: begin
        sa = 1; alu = 4'd3; pcwc = 1; pcs = 2'b01;
        bt = (op == 6'b000100) ? 2'd0 : (op == 6'b000110) ? 2'd1 :
             (op == 6'b000111) ? 2'd2 : 2'd3;
      end
      JUMP: begin
        pcw = 1; pcs = 2'b10;
        if (op == 6'b000011) begin rw = 1; rd = 2'b10; m2r = 2'b11; end
      end
      ERROR: err = 1;
      default: ;
    endcase
    return {pcw, pcwc, pcs, bt, ir, iod, mr, mw, m2r, rw, rd, sa, srcb, alu, ext, ill, err};
  endfunction

  // One controller cycle: drive inputs just after the edge, queue the expectation
  task automatic cyc(input logic [3:0] st, input logic [5:0] op, input logic [5:0] op_in,
                     input logic rdy);
    exp_t x;
    @(posedge clk);
    #1;
    instr_op_i  = op_in;
    mem_ready_i = rdy;
    x.st   = st;
    x.ctrl = ctrl_for(st, op, op_in, rdy);
    x.ret  = 2'(model_retire);
    scb.push_back(x);
  endtask

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // A wait state held for n not-ready cycles; reaching TO of them means ERROR
  task automatic wait_phase(input logic [3:0] st, input logic [5:0] op, input int n,
                            output bit timed);
    timed = 0;
    for (int i = 0; i < n && i < TO; i++) cyc(st, op, rop(), 1'b0);
    if (n >= TO) begin
      timed = 1;
      cyc(ERROR, op, rop(), rbit());
    end else begin
      cyc(st, op, rop(), 1'b1);
    end
  endtask

  task automatic instr(input logic [5:0] op, input int fw, input int mw, output bit timed);
    wait_phase(FETCH, op, fw, timed);
    if (timed) return;
    cyc(DECODE, op, op, rbit());
    if (op inside {6'o43, 6'o53}) begin
      cyc(MEMADR, op, rop(), rbit());
      wait_phase((op == 6'o43) ? MEMRD : MEMWR, op, mw, timed);
      if (timed) return;
      if (op == 6'o43) cyc(MEMWB, op, rop(), rbit());
      model_retire++;
    end else if (op == 6'o00) begin
      cyc(RTEXEC, op, rop(), rbit());
      cyc(ALUWB, op, rop(), rbit());
      model_retire++;
    end else if (op inside {6'o10, 6'o13, 6'o15, 6'o17}) begin
      cyc(ITEXEC, op, rop(), rbit());
      cyc(ALUWB, op, rop(), rbit());
      model_retire++;
    end else if (op inside {6'o04, 6'o05, 6'o06, 6'o07}) begin
      cyc(BRANCH, op, rop(), rbit());
      model_retire++;
    end else if (op inside {6'o02, 6'o03}) begin
      cyc(JUMP, op, rop(), rbit());
      model_retire++;
    end
  endtask

  task automatic release_reset();
    model_retire = 0;
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    cyc_idle();
  endtask

  task automatic cyc_idle();
    exp_t x;
    instr_op_i  = rop();
    mem_ready_i = rbit();
    x.st   = IDLE;
    x.ctrl = '0;
    x.ret  = 2'd0;
    scb.push_back(x);
  endtask

  // Asynchronous reset in the second half of a cycle, checked before the next edge
  task automatic reset_mid();
    #6;
    rst_i = 1'b0;
    #1;
    check("reset_state", 32'(state_o), 32'(IDLE));
    check("reset_ctrl", 32'(act_ctrl), 32'd0);
    check("reset_retire", 32'(retire_cnt_o), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  always @(negedge clk) begin
    cycle_no++;
    if (rst_i && scb.size() > 0) begin
      e = scb.pop_front();
      check("state", 32'(state_o), 32'(e.st));
      check("ctrl", 32'(act_ctrl), 32'(e.ctrl));
      check("retire", 32'(retire_cnt_o), 32'(e.ret));
    end
  end

  initial begin
    ops = '{6'o00, 6'o02, 6'o03, 6'o04, 6'o05, 6'o06, 6'o07, 6'o10,
            6'o13, 6'o15, 6'o17, 6'o43, 6'o53, 6'o77, 6'o01, 6'o20};
    rst_i       = 1'b0;
    instr_op_i  = '0;
    mem_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("por_state", 32'(state_o), 32'(IDLE));
    check("por_ctrl", 32'(act_ctrl), 32'd0);
    check("por_retire", 32'(retire_cnt_o), 32'd0);

    // Directed: R-type, lw with stalls, bne, jal, illegal, sw (retire wraps at 4)
    release_reset();
    instr(6'o00, 0, 0, to);
    instr(6'o43, 0, 3, to);
    instr(6'o05, 1, 0, to);
    instr(6'o03, 0, 0, to);
    instr(6'o77, 0, 0, to);
    instr(6'o53, 2, 1, to);
    instr(6'o15, 14, 0, to);
    instr(6'o43, 0, 14, to);
    instr(6'o53, 1, 14, to);

    // Randomized instruction mix with occasional boundary-length stalls
    for (int i = 0; i < 40; i++) begin
      int fw, mw;
      fw = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
      instr(ops[$urandom_range(0, 15)], fw, mw, to);
    end

    // Reset while waiting in MEMRD abandons the load
    wait_phase(FETCH, 6'o43, 0, to);
    cyc(DECODE, 6'o43, 6'o43, 1'b0);
    cyc(MEMADR, 6'o43, rop(), 1'b0);
    cyc(MEMRD, 6'o43, rop(), 1'b0);
    cyc(MEMRD, 6'o43, rop(), 1'b0);
    reset_mid();

    // Fetch timeout, then ERROR is sticky even with ready high
    release_reset();
    instr(6'o10, 20, 0, to);
    for (int i = 0; i < 5; i++) cyc(ERROR, 6'o10, rop(), 1'b1);
    reset_mid();

    // Load and store data-phase timeouts
    release_reset();
    instr(6'o00, 0, 0, to);
    instr(6'o43, 0, 15, to);
    for (int i = 0; i < 3; i++) cyc(ERROR, 6'o43, rop(), rbit());
    reset_mid();
    release_reset();
    instr(6'o53, 0, 15, to);
    for (int i = 0; i < 3; i++) cyc(ERROR, 6'o53, rop(), rbit());
    reset_mid();

    release_reset();
    instr(6'o17, 0, 0, to);
    instr(6'o02, 0, 0, to);
    @(posedge clk);
    #6;
    check("scoreboard_drained", 32'(scb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
